// File: rtl/cond_exec_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with conditional execution on {Z,N,V}.
// Optional statistics counters are enabled by defining COND_CTRL_STATS_EN.
module cond_exec_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op_class,
  input  logic [1:0]       cnd,
  input  logic             set_flags,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic             flag_we,
  output logic [2:0]       flags_q,
  output logic             ex_q,
  output logic [2:0]       state_q
`ifdef COND_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] annul_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [1:0] OP_ALU    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t st;
  logic   cond_hit;

  assign state_q = st;

  // Condition is evaluated against the flags as they stand before this instruction.
  always_comb begin
    cond_hit = 1'b0;
    case (cnd)
      2'b00:   cond_hit = flags_q[2];
      2'b01:   cond_hit = !flags_q[2] && (flags_q[1] == flags_q[0]);
      2'b10:   cond_hit = flags_q[1] != flags_q[0];
      default: cond_hit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      flags_q <= 3'b000;
      ex_q    <= 1'b0;
    end else begin
      case (st)
        IDLE:    st <= FETCH;
        FETCH:   if (mem_ready) st <= DECODE;
        DECODE: begin
          ex_q <= cond_hit;
          st   <= cond_hit ? EXEC : FETCH;
        end
        EXEC: begin
          if (set_flags) flags_q <= {alu_z, alu_n, alu_v};
          case (op_class)
            OP_ALU:    st <= WB;
            OP_BRANCH: st <= FETCH;
            default:   st <= MEM;
          endcase
        end
        MEM:     if (mem_ready) st <= (op_class == OP_LOAD) ? WB : FETCH;
        WB:      st <= FETCH;
        default: st <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state so an asynchronous reset silences them at once.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 1'b0;
    rf_we   = 1'b0;
    flag_we = 1'b0;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      EXEC: begin
        flag_we = set_flags;
        if (op_class == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_class == OP_STORE);
      end
      WB:      rf_we = 1'b1;
      default: ;
    endcase
  end

`ifdef COND_CTRL_STATS_EN
  logic retire;
  logic annul;

  always_comb begin
    retire = 1'b0;
    annul  = 1'b0;
    case (st)
      DECODE:  annul  = !cond_hit;
      EXEC:    retire = (op_class == OP_BRANCH);
      MEM:     retire = mem_ready && (op_class == OP_STORE);
      WB:      retire = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      annul_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (annul)  annul_cnt   <= annul_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
